// File: rtl/pipeline_idem_reg_pkg.sv
// Shared pipeline definitions: default field widths, the ID/EM control bundle
// and its bubble value, reused by the stage registers of the processor.
package pipeline_idem_reg_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_IMM_W    = 5;
    localparam int DEF_ALUCTL_W = 4;

    typedef struct packed {
        logic [DEF_ALUCTL_W-1:0] alucontrol;
        logic                    write;
        logic                    write_data_control;
        logic                    cbwrite;
        logic                    memwrite;
        logic                    memread;
    } idem_ctrl_t;

    localparam idem_ctrl_t IDEM_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_idem_reg_if.sv
// Decode-side fields entering the ID/EM register and the stage fields leaving it.
interface pipeline_idem_reg_if #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int IMM_W    = 5,
    parameter int ALUCTL_W = 4
) ();
    logic                valid_i;
    logic [ALUCTL_W-1:0] alucontrol_i;
    logic                write_i;
    logic                write_data_control_i;
    logic                CBwrite_i;
    logic [DATA_W-1:0]   rs_data_i;
    logic [DATA_W-1:0]   rt_data_i;
    logic [ADDR_W-1:0]   rs_addr_i;
    logic [ADDR_W-1:0]   rt_addr_i;
    logic [ADDR_W-1:0]   write_addr_i;
    logic [IMM_W-1:0]    immediate_i;
    logic                memwrite_i;
    logic                memread_i;

    logic                valid_o;
    logic [ALUCTL_W-1:0] alucontrol_o;
    logic                write_o;
    logic                write_data_control_o;
    logic                CBwrite_o;
    logic [DATA_W-1:0]   rs_data_o;
    logic [DATA_W-1:0]   rt_data_o;
    logic [ADDR_W-1:0]   rs_addr_o;
    logic [ADDR_W-1:0]   rt_addr_o;
    logic [ADDR_W-1:0]   write_addr_o;
    logic [IMM_W-1:0]    immediate_o;
    logic                memwrite_o;
    logic                memread_o;

    modport master (
        output valid_i, alucontrol_i, write_i, write_data_control_i, CBwrite_i,
               rs_data_i, rt_data_i, rs_addr_i, rt_addr_i, write_addr_i,
               immediate_i, memwrite_i, memread_i,
        input  valid_o, alucontrol_o, write_o, write_data_control_o, CBwrite_o,
               rs_data_o, rt_data_o, rs_addr_o, rt_addr_o, write_addr_o,
               immediate_o, memwrite_o, memread_o
    );

    modport slave (
        input  valid_i, alucontrol_i, write_i, write_data_control_i, CBwrite_i,
               rs_data_i, rt_data_i, rs_addr_i, rt_addr_i, write_addr_i,
               immediate_i, memwrite_i, memread_i,
        output valid_o, alucontrol_o, write_o, write_data_control_o, CBwrite_o,
               rs_data_o, rt_data_o, rs_addr_o, rt_addr_o, write_addr_o,
               immediate_o, memwrite_o, memread_o
    );

endinterface

// File: rtl/pipeline_idem_reg_refresh.sv
// Operand refresh: substitutes in-flight write-back data for a stale operand
// when the write-back targets the operand's register.
module pipe_operand_refresh #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter bit WB_BYPASS = 1'b1,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic [ADDR_W-1:0] cand_addr_i,
    input  logic [DATA_W-1:0] cand_data_i,
    input  logic              qual_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o
);
    logic addr_hit;
    logic zero_blocked;
    logic match;

    assign addr_hit     = (wb_addr_i == cand_addr_i);
    assign zero_blocked = ZERO_REG && (cand_addr_i == '0);
    assign match        = WB_BYPASS && qual_i && wb_en_i && addr_hit && !zero_blocked;
    assign data_o       = match ? wb_data_i : cand_data_i;

endmodule

// File: rtl/pipeline_idem_reg.sv
// ID/EM pipeline register with synchronous reset, stall, flush, a stage-valid
// bit and write-back refresh of the rs/rt operand data.
module pipeline_idem_reg
    import pipeline_idem_reg_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int IMM_W     = DEF_IMM_W,
    parameter int ALUCTL_W  = DEF_ALUCTL_W,
    parameter bit WB_BYPASS = 1'b1,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    pipeline_idem_reg_if.slave idem
);
    // The shared control bundle fixes the ALU control width.
    generate
        if (ALUCTL_W != DEF_ALUCTL_W) begin : g_bad_aluctl_w
            $error("pipeline_idem_reg: ALUCTL_W must equal DEF_ALUCTL_W");
        end
    endgenerate

    idem_ctrl_t        ctrl_in;
    idem_ctrl_t        ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [IMM_W-1:0]  imm_q, imm_d;

    // Index 0 is rs, index 1 is rt.
    logic [ADDR_W-1:0] opnd_addr_in   [2];
    logic [DATA_W-1:0] opnd_data_in   [2];
    logic [ADDR_W-1:0] opnd_addr_q    [2];
    logic [ADDR_W-1:0] opnd_addr_d    [2];
    logic [DATA_W-1:0] opnd_data_q    [2];
    logic [DATA_W-1:0] opnd_data_d    [2];
    logic [ADDR_W-1:0] opnd_cand_addr [2];
    logic [DATA_W-1:0] opnd_cand_data [2];
    logic [DATA_W-1:0] opnd_refreshed [2];

    assign ctrl_in = '{
        alucontrol:         idem.alucontrol_i,
        write:              idem.write_i,
        write_data_control: idem.write_data_control_i,
        cbwrite:            idem.CBwrite_i,
        memwrite:           idem.memwrite_i,
        memread:            idem.memread_i
    };

    // While stalled the held operand is refreshed, but only for a real instruction.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign opnd_addr_in[gi]   = (gi == 0) ? idem.rs_addr_i : idem.rt_addr_i;
            assign opnd_data_in[gi]   = (gi == 0) ? idem.rs_data_i : idem.rt_data_i;
            assign opnd_cand_addr[gi] = stall_i ? opnd_addr_q[gi] : opnd_addr_in[gi];
            assign opnd_cand_data[gi] = stall_i ? opnd_data_q[gi] : opnd_data_in[gi];

            pipe_operand_refresh #(
                .DATA_W    (DATA_W),
                .ADDR_W    (ADDR_W),
                .WB_BYPASS (WB_BYPASS),
                .ZERO_REG  (ZERO_REG)
            ) u_refresh (
                .cand_addr_i (opnd_cand_addr[gi]),
                .cand_data_i (opnd_cand_data[gi]),
                .qual_i      (stall_i ? valid_q : 1'b1),
                .wb_en_i     (wb_en_i),
                .wb_addr_i   (wb_addr_i),
                .wb_data_i   (wb_data_i),
                .data_o      (opnd_refreshed[gi])
            );
        end
    endgenerate

    always_comb begin
        ctrl_d       = ctrl_q;
        valid_d      = valid_q;
        write_addr_d = write_addr_q;
        imm_d        = imm_q;
        for (int k = 0; k < 2; k++) begin
            opnd_addr_d[k] = opnd_addr_q[k];
            opnd_data_d[k] = opnd_data_q[k];
        end

        if (flush_i) begin
            ctrl_d       = IDEM_CTRL_BUBBLE;
            valid_d      = 1'b0;
            write_addr_d = '0;
            imm_d        = '0;
            for (int k = 0; k < 2; k++) begin
                opnd_addr_d[k] = '0;
                opnd_data_d[k] = '0;
            end
        end else if (stall_i) begin
            for (int k = 0; k < 2; k++) begin
                opnd_data_d[k] = opnd_refreshed[k];
            end
        end else begin
            ctrl_d       = ctrl_in;
            valid_d      = idem.valid_i;
            write_addr_d = idem.write_addr_i;
            imm_d        = idem.immediate_i;
            for (int k = 0; k < 2; k++) begin
                opnd_addr_d[k] = opnd_addr_in[k];
                opnd_data_d[k] = opnd_refreshed[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q       <= IDEM_CTRL_BUBBLE;
            valid_q      <= 1'b0;
            write_addr_q <= '0;
            imm_q        <= '0;
            for (int k = 0; k < 2; k++) begin
                opnd_addr_q[k] <= '0;
                opnd_data_q[k] <= '0;
            end
        end else begin
            ctrl_q       <= ctrl_d;
            valid_q      <= valid_d;
            write_addr_q <= write_addr_d;
            imm_q        <= imm_d;
            for (int k = 0; k < 2; k++) begin
                opnd_addr_q[k] <= opnd_addr_d[k];
                opnd_data_q[k] <= opnd_data_d[k];
            end
        end
    end

    assign idem.valid_o              = valid_q;
    assign idem.alucontrol_o         = ctrl_q.alucontrol;
    assign idem.write_o              = ctrl_q.write;
    assign idem.write_data_control_o = ctrl_q.write_data_control;
    assign idem.CBwrite_o            = ctrl_q.cbwrite;
    assign idem.memwrite_o           = ctrl_q.memwrite;
    assign idem.memread_o            = ctrl_q.memread;
    assign idem.rs_addr_o            = opnd_addr_q[0];
    assign idem.rt_addr_o            = opnd_addr_q[1];
    assign idem.rs_data_o            = opnd_data_q[0];
    assign idem.rt_data_o            = opnd_data_q[1];
    assign idem.write_addr_o         = write_addr_q;
    assign idem.immediate_o          = imm_q;

endmodule

// File: tb/tb_pipeline_idem_reg.sv
// Bench for pipeline_idem_reg: three instances (bypass+zero-reg, no bypass,
// bypass without zero-reg) share stimulus and are compared to a rule-level model.
module tb_pipeline_idem_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, stall, flush, valid_in;
    logic [3:0] alu_in;
    logic       w_in, wdc_in, cb_in, mw_in, mr_in;
    logic [7:0] rsd_in, rtd_in;
    logic [2:0] rsa_in, rta_in, wa_in;
    logic [4:0] imm_in;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;

    // Packed view: valid|alu|w|wdc|cb|mw|mr|rs_data|rt_data|rs_addr|rt_addr|write_addr|imm
    logic [39:0] obs [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            pipeline_idem_reg_if #(.DATA_W(8), .ADDR_W(3), .IMM_W(5), .ALUCTL_W(4)) bus ();

            assign bus.valid_i              = valid_in;
            assign bus.alucontrol_i         = alu_in;
            assign bus.write_i              = w_in;
            assign bus.write_data_control_i = wdc_in;
            assign bus.CBwrite_i            = cb_in;
            assign bus.memwrite_i           = mw_in;
            assign bus.memread_i            = mr_in;
            assign bus.rs_data_i            = rsd_in;
            assign bus.rt_data_i            = rtd_in;
            assign bus.rs_addr_i            = rsa_in;
            assign bus.rt_addr_i            = rta_in;
            assign bus.write_addr_i         = wa_in;
            assign bus.immediate_i          = imm_in;

            pipeline_idem_reg #(
                .DATA_W    (8),
                .ADDR_W    (3),
                .IMM_W     (5),
                .ALUCTL_W  (4),
                .WB_BYPASS ((gi == 1) ? 1'b0 : 1'b1),
                .ZERO_REG  ((gi == 2) ? 1'b0 : 1'b1)
            ) dut (
                .clk_i     (clk),
                .rst_i     (rst),
                .stall_i   (stall),
                .flush_i   (flush),
                .wb_en_i   (wb_en),
                .wb_addr_i (wb_addr),
                .wb_data_i (wb_data),
                .idem      (bus)
            );

            assign obs[gi] = {bus.valid_o, bus.alucontrol_o, bus.write_o,
                              bus.write_data_control_o, bus.CBwrite_o, bus.memwrite_o,
                              bus.memread_o, bus.rs_data_o, bus.rt_data_o, bus.rs_addr_o,
                              bus.rt_addr_o, bus.write_addr_o, bus.immediate_o};
        end
    endgenerate

    typedef struct {
        bit       v;
        bit [3:0] alu;
        bit       w, wdc, cb, mw, mr;
        bit [7:0] rsd, rtd;
        bit [2:0] rsa, rta, wa;
        bit [4:0] imm;
    } st_t;

    st_t mdl [3];
    int  checks = 0;
    int  errors = 0;
    int  cycle  = 0;

    function automatic bit bypass_of(int k);
        return (k != 1);
    endfunction

    function automatic bit zeroreg_of(int k);
        return (k != 2);
    endfunction

    // Would a write-back this cycle overwrite an operand read from register a?
    function automatic bit wb_hits(int k, bit [2:0] a);
        if (!bypass_of(k) || !wb_en) return 1'b0;
        if (zeroreg_of(k) && a == 3'd0) return 1'b0;
        return (wb_addr == a);
    endfunction

    function automatic logic [39:0] pack(st_t s);
        return {s.v, s.alu, s.w, s.wdc, s.cb, s.mw, s.mr, s.rsd, s.rtd, s.rsa, s.rta, s.wa, s.imm};
    endfunction

    task automatic model_edge(int k);
        st_t s;
        s = mdl[k];
        if (rst || flush) begin
            s = '{default: 0};
        end else if (stall) begin
            if (s.v && wb_hits(k, s.rsa)) s.rsd = wb_data;
            if (s.v && wb_hits(k, s.rta)) s.rtd = wb_data;
        end else begin
            s.v   = valid_in;
            s.alu = alu_in;
            s.w   = w_in;
            s.wdc = wdc_in;
            s.cb  = cb_in;
            s.mw  = mw_in;
            s.mr  = mr_in;
            s.rsa = rsa_in;
            s.rta = rta_in;
            s.wa  = wa_in;
            s.imm = imm_in;
            s.rsd = wb_hits(k, rsa_in) ? wb_data : rsd_in;
            s.rtd = wb_hits(k, rta_in) ? wb_data : rtd_in;
        end
        mdl[k] = s;
    endtask

    task automatic chk(string tag, logic [39:0] got, logic [39:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        cycle++;
        $display("cyc %0d rst=%b fl=%b st=%b v=%b wb=%b/%0d/%h out0=%h", cycle, rst, flush,
                 stall, valid_in, wb_en, wb_addr, wb_data, obs[0]);
        for (int k = 0; k < 3; k++) chk($sformatf("cyc%0d_dut%0d", cycle, k), obs[k], pack(mdl[k]));
    endtask

    task automatic rand_inputs();
        valid_in = 1'($urandom);
        alu_in   = 4'($urandom);
        w_in     = 1'($urandom);
        wdc_in   = 1'($urandom);
        cb_in    = 1'($urandom);
        mw_in    = 1'($urandom);
        mr_in    = 1'($urandom);
        rsd_in   = 8'($urandom);
        rtd_in   = 8'($urandom);
        rsa_in   = 3'($urandom);
        rta_in   = 3'($urandom);
        wa_in    = 3'($urandom);
        imm_in   = 5'($urandom);
        wb_data  = 8'($urandom);
    endtask

    task automatic load(bit [2:0] ra, bit [7:0] rd, bit [2:0] ta, bit [7:0] td);
        rand_inputs();
        rst = 0; stall = 0; flush = 0; wb_en = 0; valid_in = 1;
        rsa_in = ra; rsd_in = rd; rta_in = ta; rtd_in = td;
        cyc();
    endtask

    logic [39:0] o;

    initial begin
        for (int k = 0; k < 3; k++) mdl[k] = '{default: 0};
        rst = 1; stall = 0; flush = 0; wb_en = 0; wb_addr = 0;
        rand_inputs();
        valid_in = 1; alu_in = 4'hF; rsd_in = 8'hFF; mw_in = 1;

        // Reset with nonzero inputs, two edges
        cyc();
        cyc();
        chk("rst_all_zero", obs[0], 40'h0);
        rst = 0; alu_in = 4'hA;
        cyc();
        o = obs[0];
        chk("release_alu", 40'(o[38:35]), 40'hA);

        // Load then hold for three stalls with churning inputs
        load(3'd1, 8'h11, 3'd4, 8'h22);
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1; wb_en = 0;
            cyc();
        end
        o = obs[0];
        chk("hold_rs", 40'(o[29:22]), 40'h11);
        chk("hold_rt", 40'(o[21:14]), 40'h22);
        chk("hold_valid", 40'(o[39]), 40'h1);

        // Stall refresh of rs only
        load(3'd3, 8'h44, 3'd5, 8'h77);
        rand_inputs();
        stall = 1; wb_en = 1; wb_addr = 3'd3; wb_data = 8'h5C;
        cyc();
        o = obs[0];
        chk("stall_ref_rs", 40'(o[29:22]), 40'h5C);
        chk("stall_ref_rt", 40'(o[21:14]), 40'h77);

        // Register 0 refresh: blocked where it is hardwired zero
        load(3'd0, 8'h33, 3'd6, 8'h66);
        rand_inputs();
        stall = 1; wb_en = 1; wb_addr = 3'd0; wb_data = 8'hE7;
        cyc();
        o = obs[0];
        chk("zero_reg_block", 40'(o[29:22]), 40'h33);
        o = obs[2];
        chk("zero_reg_off", 40'(o[29:22]), 40'hE7);

        // Load bypass, rs and rt on the same register
        rand_inputs();
        stall = 0; valid_in = 1;
        rsa_in = 3'd2; rta_in = 3'd2; rsd_in = 8'h01; rtd_in = 8'h01;
        wb_en = 1; wb_addr = 3'd2; wb_data = 8'h99;
        cyc();
        o = obs[0];
        chk("bypass_rs", 40'(o[29:22]), 40'h99);
        chk("bypass_rt", 40'(o[21:14]), 40'h99);
        o = obs[1];
        chk("nobypass_rs", 40'(o[29:22]), 40'h01);
        chk("nobypass_rt", 40'(o[21:14]), 40'h01);

        // Flush wins over stall; a bubble is never refreshed
        rand_inputs();
        stall = 0; wb_en = 0; valid_in = 1; mw_in = 1;
        cyc();
        stall = 1; flush = 1;
        cyc();
        for (int k = 0; k < 3; k++) chk($sformatf("flush_dut%0d", k), obs[k], 40'h0);
        flush = 0; stall = 1; wb_en = 1; wb_addr = 3'd0; wb_data = 8'hAB;
        cyc();
        o = obs[2];
        chk("bubble_no_ref", 40'(o[29:22]), 40'h0);

        // Reset in the middle of a stall, then a normal load
        load(3'd4, 8'h5A, 3'd7, 8'hA5);
        stall = 1; wb_en = 0;
        cyc();
        rst = 1;
        cyc();
        chk("midstall_rst", obs[0], 40'h0);
        rand_inputs();
        rst = 0; stall = 0; valid_in = 1; rsd_in = 8'h3C; wb_en = 0;
        cyc();
        o = obs[0];
        chk("post_rst_load", {32'h0, o[39], o[29:22]}, {32'h0, 1'b1, 8'h3C});

        // Randomised traffic with write-backs biased toward live operands
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 2) == 0);
            wb_en = 1'($urandom);
            case ($urandom_range(0, 3))
                0: wb_addr = mdl[0].rsa;
                1: wb_addr = mdl[0].rta;
                2: wb_addr = rsa_in;
                default: wb_addr = 3'($urandom);
            endcase
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_idem_reg.md
Name: pipeline_idem_reg

Overview:
Parametrised ID/EM pipeline register, successor of the fixed 8-bit decode-to-execute/memory stage register.
- Adds synchronous reset, stall (hold) and flush (bubble insert), plus a stage-valid bit.
- Adds write-back operand refresh: held and captured rs/rt data never go stale while a write-back to the same register is in flight.
- Sits between the decode stage and the execute/memory stage of the pipelined processor; the hazard unit drives stall_i and flush_i.

Parameters:
DATA_W, 8, register-file data width
ADDR_W, 3, register address width
IMM_W, 5, immediate field width
ALUCTL_W, 4, ALU control width
WB_BYPASS, 1, 1 = forward same-cycle write-back data into rs/rt data at capture and while held
ZERO_REG, 1, 1 = register address 0 is hardwired zero and is never refreshed by write-back

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
stall_i  in  1  hold all outputs this cycle
flush_i  in  1  replace stage contents with a bubble
valid_i  in  1  decode stage holds a real instruction
alucontrol_i / alucontrol_o  in/out  ALUCTL_W  ALU operation
write_i / write_o  in/out  1  register-file write enable
write_data_control_i / write_data_control_o  in/out  1  write-back source select
CBwrite_i / CBwrite_o  in/out  1  condition-bit write enable
rs_data_i / rs_data_o, rt_data_i / rt_data_o  in/out  DATA_W  operand data
rs_addr_i / rs_addr_o, rt_addr_i / rt_addr_o, write_addr_i / write_addr_o  in/out  ADDR_W  register addresses
immediate_i / immediate_o  in/out  IMM_W  immediate
memwrite_i / memwrite_o, memread_i / memread_o  in/out  1  memory controls
wb_en_i  in  1  write-back stage writing the register file this cycle
wb_addr_i  in  ADDR_W  write-back destination
wb_data_i  in  DATA_W  write-back data
valid_o  out  1  stage holds a real instruction

Behaviour:
- Reset value of every output, including valid_o, is 0.
- Latency: 1 cycle from input to output on a load.
- Per-edge priority is rst_i > flush_i > stall_i > load.
- Flush: all outputs become 0 and valid_o becomes 0. Flush with stall set is still a flush.
- Stall: all fields hold, except the operand refresh below. valid_o holds.
- Load: every field takes its _i value, and valid_o takes valid_i.
- Invalid instructions pass their fields unchanged; consumers qualify every output with valid_o.
- Refresh match for rs (rt identical):
  - WB_BYPASS=1, wb_en_i=1, and the address compares equal;
  - and not (ZERO_REG=1 and address==0).
- Load refresh: compare wb_addr_i against rs_addr_i. On a match rs_data_o takes wb_data_i instead of rs_data_i.
- Stall refresh: compare wb_addr_i against the held rs_addr_o, and only when valid_o=1. On a match rs_data_o takes wb_data_i.
- rs and rt refresh independently; rs_addr==rt_addr refreshes both.
- A write-back whose wb_addr_i equals write_addr_o does not affect write_addr_o or any control field.
- No refresh on reset or flush cycles.
- Widths are pure pass-through. There is no arithmetic, sign extension or truncation.
- Reset asserted mid-stall clears everything. The first edge after rst_i deasserts performs a normal load, or a stall or flush if those are asserted.
- WB_BYPASS=0: the block is a plain stall/flush register and wb_* inputs are ignored.

Decomposition:
- Shared pipeline package holds:
  - a typedef for the ID/EM control bundle (alucontrol, write, write_data_control, CBwrite, memwrite, memread);
  - a constant for the bubble value (all zero);
  - the default width constants, reused by the other stage registers.
- One sub-module, pipe_operand_refresh: the comparator plus mux. It takes candidate address, candidate data, valid qualifier and wb_*, and returns the next data. It is instantiated twice (rs, rt).
- Control and address fields stay inline.

Test Plan:
- Reset: rst_i=1 with all inputs nonzero for 2 edges -> all outputs 0, valid_o=0. Release -> next edge captures the inputs (alucontrol_i=4'hA appears as alucontrol_o=4'hA).
- Load then stall: load rs_data_i=8'h11, rt_data_i=8'h22, valid_i=1. Then 3 stall cycles with changing inputs and wb_en_i=0 -> outputs stay 8'h11/8'h22, valid_o=1.
- Stall refresh: hold rs_addr_o=3, rt_addr_o=5; stall with wb_en_i=1, wb_addr_i=3, wb_data_i=8'h5C -> rs_data_o=8'h5C, rt_data_o unchanged. With ZERO_REG=1 and held rs_addr_o=0, wb_addr_i=0 -> no change.
- Load bypass: rs_addr_i=rt_addr_i=2, rs_data_i=8'h01, rt_data_i=8'h01, wb_en_i=1, wb_addr_i=2, wb_data_i=8'h99 -> rs_data_o=rt_data_o=8'h99. Repeat with WB_BYPASS=0 -> both 8'h01.
- Flush priority: stall_i=1, flush_i=1 with memwrite_o=1 held -> next edge all outputs 0, valid_o=0. Then stall alone with wb_addr matching -> data stays 0 (valid_o=0 blocks refresh).
- Mid-stall reset: stall with valid_o=1, then rst_i=1 -> all 0. Then rst_i=0, stall_i=0, valid_i=1 -> load on the next edge.
